// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Big-endian lane numbering: byte offset 0 is the MSB lane.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EXT,
    S_MERGE,
    S_WR,
    S_RESP
  } state_t;

  // Right-shift that brings the addressed byte lane down to [7:0].
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Lane extraction/extension for loads and lane merge for stores.
// Purely combinational.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] sdata
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  // A halfword at offset 0 shares its low byte with offset 1.
  assign bsh = lane_shift(off);
  assign hsh = lane_shift({off[1], 1'b1});
  assign b   = 8'(word >> bsh);
  assign h   = 16'(word >> hsh);

  always_comb begin
    ldata = word;
    sdata = wdata;
    unique case (funct3)
      F3_B: begin
        ldata = {{24{b[7]}}, b};
        sdata = (word & ~(32'h0000_00ff << bsh))
              | ({24'h0, wdata[7:0]} << bsh);
      end
      F3_H: begin
        ldata = {{16{h[15]}}, h};
        sdata = (word & ~(32'h0000_ffff << hsh))
              | ({16'h0, wdata[15:0]} << hsh);
      end
      F3_BU: ldata = {24'h0, b};
      F3_HU: ldata = {16'h0, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide registered memory.
// Sub-word stores are read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state;
  state_t        state_n;
  logic          wr_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [DW-1:0] wdata_q;
  logic          accept;
  logic          req_err;
  logic [DW-1:0] ld_word;
  logic [DW-1:0] st_word;

  assign req_ready  = (state == S_IDLE) & ~rst;
  assign accept     = req_valid & req_ready;
  assign mem_read   = (state == S_RD) & ~rst;
  assign mem_write  = (state == S_WR) & ~rst;
  assign resp_valid = (state == S_RESP) & ~rst;

  always_comb begin
    req_err = 1'b0;
    unique case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = |req_addr[1:0];
      F3_BU:   req_err = req_write;
      F3_HU:   req_err = req_write | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)
            state_n = S_RESP;
          else if (req_write && req_funct3 == F3_W)
            state_n = S_WR;
          else
            state_n = S_RD;
        end
      end
      S_RD:    state_n = wr_q ? S_MERGE : S_EXT;
      S_EXT:   state_n = S_RESP;
      S_MERGE: state_n = S_WR;
      S_WR:    state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        wr_q        <= req_write;
        f3_q        <= req_funct3;
        off_q       <= req_addr[1:0];
        wdata_q     <= req_wdata;
        mem_address <= {req_addr[AW-1:2], 2'b00};
        mem_wdata   <= req_wdata;
        resp_rdata  <= '0;
        resp_err    <= req_err;
      end
      if (state == S_EXT)
        resp_rdata <= ld_word;
      if (state == S_MERGE)
        mem_wdata <= st_word;
    end
  end

  lsu_byte_lane u_lane (
    .off    (off_q),
    .funct3 (f3_q),
    .word   (mem_rdata),
    .wdata  (wdata_q),
    .ldata  (ld_word),
    .sdata  (st_word)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small big-endian
// registered-read word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        mem_init = 1'b1;
  logic [31:0] mem [0:63];
  int          wr_cnt;

  int total = 0;
  int bad = 0;

  logic        acc_ok;
  logic        r_rd    [0:7];
  logic        r_wr    [0:7];
  logic        r_rv    [0:7];
  logic        r_err   [0:7];
  logic        r_rdy   [0:7];
  logic [31:0] r_rdata [0:7];
  logic [31:0] r_addr  [0:7];
  logic [31:0] r_wdata [0:7];

  always #5 clk = ~clk;

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'h8012_34f5;
      mem_rdata <= 32'h0;
      wr_cnt    <= 0;
    end else begin
      if (mem_read) mem_rdata <= mem[mem_address[7:2]];
      if (mem_write) begin
        mem[mem_address[7:2]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic run_req(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    acc_ok     = req_ready;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) req_valid = 1'b0;
      r_rd[c]    = mem_read;
      r_wr[c]    = mem_write;
      r_rv[c]    = resp_valid;
      r_err[c]   = resp_err;
      r_rdy[c]   = req_ready;
      r_rdata[c] = resp_rdata;
      r_addr[c]  = mem_address;
      r_wdata[c] = mem_wdata;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    total++;
    if ({resp_valid, mem_read, mem_write, resp_err} !== 4'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b exp=0000",
               {resp_valid, mem_read, mem_write, resp_err});
    end
    total++;
    if ({mem_address, mem_wdata, resp_rdata} !== 96'h0) begin
      bad++;
      $display("FAIL reset_regs got=%h %h %h exp=0",
               mem_address, mem_wdata, resp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_lw();
    int n;
    run_req(1'b0, F3_W, 32'h10, 32'h0);
    total++;
    if (acc_ok !== 1'b1) begin
      bad++;
      $display("FAIL lw_accept got=%b exp=1", acc_ok);
    end
    for (int c = 1; c < 8; c++) begin
      total++;
      if (r_rd[c] !== (c == 1)) begin
        bad++;
        $display("FAIL lw_mem_read c%0d got=%b exp=%b", c, r_rd[c], c == 1);
      end
    end
    total++;
    if (r_addr[1] !== 32'h10) begin
      bad++;
      $display("FAIL lw_addr got=%h exp=00000010", r_addr[1]);
    end
    total++;
    if ({r_rv[3], r_err[3], r_rdata[3]} !== {2'b10, 32'h8012_34f5}) begin
      bad++;
      $display("FAIL lw_resp got=%b %b %h exp=1 0 801234f5",
               r_rv[3], r_err[3], r_rdata[3]);
    end
    n = 0;
    for (int c = 1; c < 8; c++) n += int'(r_rv[c]);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL lw_pulses got=%0d exp=1", n);
    end
  endtask

  task automatic test_subword();
    logic [2:0]  f3s [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_H};
    logic [31:0] as  [6] = '{32'h10, 32'h13, 32'h10, 32'h12, 32'h13, 32'h12};
    logic [31:0] ex  [6] = '{32'hffff_ff80, 32'h0000_00f5, 32'hffff_8012,
                             32'h0000_34f5, 32'hffff_fff5, 32'h0000_34f5};
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, f3s[i], as[i], 32'h0);
      total++;
      if ({r_rv[3], r_err[3], r_rdata[3]} !== {2'b10, ex[i]}) begin
        bad++;
        $display("FAIL subword_load%0d got=%b %b %h exp=1 0 %h",
                 i, r_rv[3], r_err[3], r_rdata[3], ex[i]);
      end
    end
  endtask

  task automatic test_err();
    logic        ws  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [4] = '{F3_H, 3'b011, F3_W, F3_BU};
    logic [31:0] as  [4] = '{32'h11, 32'h10, 32'h12, 32'h10};
    int traffic;
    int w0;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt;
      run_req(ws[i], f3s[i], as[i], 32'hffff_ffff);
      traffic = 0;
      for (int c = 1; c < 8; c++) traffic += int'(r_rd[c]) + int'(r_wr[c]);
      total++;
      if ({r_rv[1], r_err[1], r_rdata[1]} !== {2'b11, 32'h0}) begin
        bad++;
        $display("FAIL err_resp%0d got=%b %b %h exp=1 1 0",
                 i, r_rv[1], r_err[1], r_rdata[1]);
      end
      total++;
      if (traffic !== 0 || wr_cnt !== w0) begin
        bad++;
        $display("FAIL err_traffic%0d got=%0d exp=0", i, traffic);
      end
      total++;
      if ({r_rv[2], r_rdy[2]} !== 2'b01) begin
        bad++;
        $display("FAIL err_after%0d got=%b exp=01", i, {r_rv[2], r_rdy[2]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int   w0;
    w0 = wr_cnt;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h10;
    req_wdata  = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_write !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_in_wr got=%b exp=1", mem_write);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({mem_write, resp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_gate got=%b exp=00", {mem_write, resp_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got=%b exp=1", req_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      seen = seen | mem_write | resp_valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet got=%b exp=0", seen);
    end
    total++;
    if (mem[4] !== 32'h8012_34f5 || wr_cnt !== w0) begin
      bad++;
      $display("FAIL rstmid_mem got=%h exp=801234f5", mem[4]);
    end
  endtask

  task automatic test_sb();
    int n;
    int w0;
    w0 = wr_cnt;
    run_req(1'b1, F3_B, 32'h11, 32'h0000_00ab);
    n = 0;
    for (int c = 1; c < 8; c++) n += int'(r_wr[c]);
    total++;
    if ({r_rd[1], r_wr[3], r_rv[4]} !== 3'b111) begin
      bad++;
      $display("FAIL sb_timing got=%b exp=111", {r_rd[1], r_wr[3], r_rv[4]});
    end
    total++;
    if (n !== 1 || wr_cnt !== w0 + 1) begin
      bad++;
      $display("FAIL sb_write_count got=%0d exp=1", n);
    end
    total++;
    if ({r_addr[3], r_wdata[3]} !== {32'h10, 32'h80ab_34f5}) begin
      bad++;
      $display("FAIL sb_wdata got=%h %h exp=00000010 80ab34f5",
               r_addr[3], r_wdata[3]);
    end
    total++;
    if ({r_err[4], r_rdata[4]} !== 33'h0) begin
      bad++;
      $display("FAIL sb_resp got=%b %h exp=0 0", r_err[4], r_rdata[4]);
    end
    run_req(1'b0, F3_W, 32'h10, 32'h0);
    total++;
    if (r_rdata[3] !== 32'h80ab_34f5) begin
      bad++;
      $display("FAIL sb_readback got=%h exp=80ab34f5", r_rdata[3]);
    end
    run_req(1'b1, F3_H, 32'h12, 32'hffff_5566);
    total++;
    if ({r_wr[3], r_wdata[3]} !== {1'b1, 32'h80ab_5566}) begin
      bad++;
      $display("FAIL sh_wdata got=%b %h exp=1 80ab5566", r_wr[3], r_wdata[3]);
    end
    run_req(1'b0, F3_W, 32'h10, 32'h0);
    total++;
    if (r_rdata[3] !== 32'h80ab_5566) begin
      bad++;
      $display("FAIL sh_readback got=%h exp=80ab5566", r_rdata[3]);
    end
  endtask

  task automatic test_back_to_back();
    int          rv1 = -1;
    int          rv2 = -1;
    int          acc2 = -1;
    logic        early = 1'b0;
    logic [31:0] rd2 = 32'h0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h20;
    req_wdata  = 32'hdead_beef;
    for (int c = 1; c < 13; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        req_write = 1'b0;
        req_wdata = 32'h0;
      end
      if (c <= 2) early = early | req_ready;
      if (resp_valid) begin
        if (rv1 < 0) rv1 = c;
        else if (rv2 < 0) begin
          rv2 = c;
          rd2 = resp_rdata;
        end
      end
      if (acc2 >= 0) req_valid = 1'b0;
      else if (req_ready) acc2 = c;
    end
    req_valid = 1'b0;
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready_low got=%b exp=0", early);
    end
    total++;
    if (rv1 !== 2 || acc2 !== 3) begin
      bad++;
      $display("FAIL b2b_accept got=rv%0d acc%0d exp=rv2 acc3", rv1, acc2);
    end
    total++;
    if (rv2 !== 6 || rd2 !== 32'hdead_beef) begin
      bad++;
      $display("FAIL b2b_load got=c%0d %h exp=c6 deadbeef", rv2, rd2);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_subword();
    test_err();
    test_reset_mid();
    test_sb();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
